// File: rtl/cnn_window_gen_if.sv
// Pixel-in / window-out handshake bundle for the 3x3 window generator.
// master = pixel source and window consumer side, slave = window generator.
interface cnn_window_gen_if #(
  parameter int DATA_WIDTH = 8
);
  logic signed [DATA_WIDTH-1:0] pix_i;
  logic                         pix_valid_i;
  logic                         pix_ready_o;
  logic signed [DATA_WIDTH-1:0] window_o [0:8];
  logic                         win_valid_o;
  logic                         win_ready_i;
  logic                         win_last_o;

  modport master (
    output pix_i, pix_valid_i, win_ready_i,
    input  pix_ready_o, window_o, win_valid_o, win_last_o
  );

  modport slave (
    input  pix_i, pix_valid_i, win_ready_i,
    output pix_ready_o, window_o, win_valid_o, win_last_o
  );
endinterface

// File: rtl/cnn_window_gen.sv
// Streaming 3x3 valid-padding window generator: raster pixels in, one registered window per position out.
// Window appears 1 cycle after its bottom-right pixel; a held window stalls pixel intake and all state.
module cnn_window_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  cnn_window_gen_if.slave    win_if
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]                col_q;
  logic [RW-1:0]                row_q;
  logic signed [DATA_WIDTH-1:0] lb1_q   [0:IMG_W-1];
  logic signed [DATA_WIDTH-1:0] lb2_q   [0:IMG_W-1];
  logic signed [DATA_WIDTH-1:0] sr_q    [0:8];
  logic signed [DATA_WIDTH-1:0] sr_nxt  [0:8];
  logic signed [DATA_WIDTH-1:0] out_q   [0:8];
  logic                         valid_q;
  logic                         last_q;
  logic                         acc;
  logic                         emit;

  assign win_if.pix_ready_o = !valid_q || win_if.win_ready_i;
  assign win_if.win_valid_o = valid_q;
  assign win_if.win_last_o  = last_q;
  assign win_if.window_o    = out_q;

  assign acc  = win_if.pix_valid_i && win_if.pix_ready_o;
  assign emit = acc && (row_q >= RW'(2)) && (col_q >= CW'(2));

  // Shift every row left and append the column {r-2, r-1, current} at the right.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      sr_nxt[r*3+0] = sr_q[r*3+1];
      sr_nxt[r*3+1] = sr_q[r*3+2];
    end
    sr_nxt[2] = lb2_q[col_q];
    sr_nxt[5] = lb1_q[col_q];
    sr_nxt[8] = win_if.pix_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      for (int i = 0; i < IMG_W; i++) begin
        lb1_q[i] <= '0;
        lb2_q[i] <= '0;
      end
      for (int i = 0; i < 9; i++) begin
        sr_q[i]  <= '0;
        out_q[i] <= '0;
      end
    end else begin
      if (acc) begin
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
        lb2_q[col_q] <= lb1_q[col_q];
        lb1_q[col_q] <= win_if.pix_i;
        sr_q         <= sr_nxt;
      end

      // A fresh emit overrides the consume so back-to-back windows keep valid high.
      if (emit) begin
        out_q   <= sr_nxt;
        valid_q <= 1'b1;
        last_q  <= (row_q == ROW_LAST) && (col_q == COL_LAST);
      end else if (valid_q && win_if.win_ready_i) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cnn_window_gen.sv
// Directed bench for cnn_window_gen: 4x4 frames with hand-derived windows plus a 28x28 randomized-handshake frame.
module tb_cnn_window_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cnn_window_gen_if #(.DATA_WIDTH(8)) s_if ();
  cnn_window_gen_if #(.DATA_WIDTH(8)) b_if ();

  cnn_window_gen #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(4)) u_small (
    .clk_i (clk),
    .rst_ni(rst_n),
    .win_if(s_if.slave)
  );

  cnn_window_gen #(.DATA_WIDTH(8), .IMG_W(28), .IMG_H(28)) u_big (
    .clk_i (clk),
    .rst_ni(rst_n),
    .win_if(b_if.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]  img [0:27][0:27];
  logic [71:0] expq [$];
  bit          lastq [$];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] pack_s();
    logic [71:0] v = '0;
    for (int i = 0; i < 9; i++) v = {v[63:0], s_if.window_o[i]};
    return v;
  endfunction

  function automatic logic [71:0] pack_b();
    logic [71:0] v = '0;
    for (int i = 0; i < 9; i++) v = {v[63:0], b_if.window_o[i]};
    return v;
  endfunction

  // mode 0: value = off + raster index; mode 1: alternating -128 / 127
  function automatic logic [7:0] pval(input int mode, input int off, input int idx);
    if (mode == 1) return (idx % 2 == 1) ? 8'h7F : 8'h80;
    return 8'(off + idx);
  endfunction

  // Window whose bottom-right pixel is raster index k of a 4-wide frame.
  function automatic logic [71:0] exp_small(input int mode, input int off, input int k);
    logic [71:0] v = '0;
    int tl = k - 10;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v = {v[63:0], pval(mode, off, tl + i*4 + j)};
    return v;
  endfunction

  task automatic cyc_s(input logic [7:0] p, input bit v, input bit r);
    s_if.pix_i       = p;
    s_if.pix_valid_i = v;
    s_if.win_ready_i = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input int mode, input int off, input int stall, inout int nwin);
    bit e;
    for (int k = 0; k < 16; k++) begin
      if (k == 11) begin
        for (int s = 0; s < stall; s++) begin
          s_if.pix_i       = pval(mode, off, k);
          s_if.pix_valid_i = 1'b1;
          s_if.win_ready_i = 1'b0;
          #1;
          chk($sformatf("%s_stall%0d_pix_ready", tag, s), s_if.pix_ready_o, 1'b0);
          @(posedge clk);
          @(negedge clk);
          chk($sformatf("%s_stall%0d_valid", tag, s), s_if.win_valid_o, 1'b1);
          chk($sformatf("%s_stall%0d_window", tag, s), pack_s(), exp_small(mode, off, 10));
          chk($sformatf("%s_stall%0d_last", tag, s), s_if.win_last_o, 1'b0);
        end
      end
      s_if.pix_i       = pval(mode, off, k);
      s_if.pix_valid_i = 1'b1;
      s_if.win_ready_i = 1'b1;
      #1;
      chk($sformatf("%s_k%0d_pix_ready", tag, k), s_if.pix_ready_o, 1'b1);
      @(posedge clk);
      @(negedge clk);
      e = (k == 10) || (k == 11) || (k == 14) || (k == 15);
      chk($sformatf("%s_k%0d_valid", tag, k), s_if.win_valid_o, e);
      if (e) begin
        nwin++;
        chk($sformatf("%s_k%0d_window", tag, k), pack_s(), exp_small(mode, off, k));
        chk($sformatf("%s_k%0d_last", tag, k), s_if.win_last_o, k == 15);
      end
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, s_if.win_valid_o, 1'b0);
    chk({tag, "_last"}, s_if.win_last_o, 1'b0);
    chk({tag, "_window"}, pack_s(), 72'd0);
    chk({tag, "_big_valid"}, b_if.win_valid_o, 1'b0);
  endtask

  initial begin
    int nwin;
    int r, c, npix, nout, ncyc;
    logic [71:0] v;

    rst_n = 1'b0;
    s_if.pix_i = '0; s_if.pix_valid_i = 1'b0; s_if.win_ready_i = 1'b1;
    b_if.pix_i = '0; b_if.pix_valid_i = 1'b0; b_if.win_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;
    #1;
    chk("reset_pix_ready", s_if.pix_ready_o, 1'b1);
    @(negedge clk);

    nwin = 0;
    run_frame("basic", 0, 0, 0, nwin);
    chk("basic_count", nwin, 4);

    nwin = 0;
    run_frame("bp", 0, 0, 3, nwin);
    chk("bp_count", nwin, 4);

    nwin = 0;
    run_frame("b2b_f0", 0, 0, 0, nwin);
    run_frame("b2b_f1", 0, 100, 0, nwin);
    chk("b2b_count", nwin, 8);

    nwin = 0;
    run_frame("signed", 1, 0, 0, nwin);
    chk("signed_count", nwin, 4);

    // Abort a frame after 9 pixels; nothing may be emitted before the reset.
    for (int k = 0; k < 9; k++) begin
      cyc_s(pval(0, 50, k), 1'b1, 1'b1);
      chk($sformatf("midrst_k%0d_valid", k), s_if.win_valid_o, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    nwin = 0;
    run_frame("post_rst", 0, 0, 0, nwin);
    chk("post_rst_count", nwin, 4);
    s_if.pix_valid_i = 1'b0;

    // 28x28 frame with random valid gaps and random consumer backpressure.
    r = 0; c = 0; npix = 0; nout = 0; ncyc = 0;
    while (nout < 676 && ncyc < 20000) begin
      b_if.pix_valid_i = (npix < 784) && ($urandom_range(0, 3) != 0);
      b_if.pix_i       = 8'($urandom);
      b_if.win_ready_i = ($urandom_range(0, 3) != 0);
      #1;
      if (b_if.win_valid_o && b_if.win_ready_i) begin
        if (expq.size() == 0) begin
          chk($sformatf("rand_unexpected_win%0d", nout), 1'b1, 1'b0);
        end else begin
          chk($sformatf("rand_win%0d", nout), pack_b(), expq.pop_front());
          chk($sformatf("rand_last%0d", nout), b_if.win_last_o, lastq.pop_front());
        end
        nout++;
      end
      if (b_if.pix_valid_i && b_if.pix_ready_o) begin
        img[r][c] = b_if.pix_i;
        if (r >= 2 && c >= 2) begin
          v = '0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              v = {v[63:0], img[r-2+i][c-2+j]};
          expq.push_back(v);
          lastq.push_back(r == 27 && c == 27);
        end
        npix++;
        if (c == 27) begin
          c = 0;
          r = (r == 27) ? 0 : r + 1;
        end else begin
          c++;
        end
      end
      @(posedge clk);
      @(negedge clk);
      ncyc++;
    end
    chk("rand_window_count", nout, 676);
    chk("rand_pixel_count", npix, 784);
    chk("rand_queue_empty", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
